ptw_arbiter: RTL

- Shares the single page-table walker between the instruction-fetch side (port 0) and the data side (port 1).
- Each side gets one translation cache entry. A hit answers the requester without a walk.
- On a miss, the block arbitrates round-robin, pulses the walker enable, waits for walker ready, and returns the leaf PTE.
- Sits between the fetch/LSU translation requests and va_to_pa; it owns va_to_pa's enable and virt_addr inputs.

---
 rtl/ptw_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ptw_arbiter.sv
// ptw_arbiter: shares one page-table walker between the fetch port (0) and
// the data port (1). Each port owns a single-entry translation cache; hits
// answer the next cycle, misses are arbitrated round-robin and walked.

// One cached translation per port: valid, VPN tag and leaf PTE.
module ptw_entry #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int VPN_WIDTH      = 36
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      fill,
  input  logic [VPN_WIDTH-1:0]      fill_tag,
  input  logic [BUS_DATA_WIDTH-1:0] fill_pte,
  input  logic [VPN_WIDTH-1:0]      look_tag,
  output logic                      match,
  output logic [BUS_DATA_WIDTH-1:0] pte
);

  logic                 valid;
  logic [VPN_WIDTH-1:0] tag;

  // Flush beats a fill in the same cycle so a stale translation never lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      tag   <= '0;
      pte   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      pte   <= fill_pte;
    end
  end

  // Tag compare ignores the page offset; the caller passes va[47:12].
  always_comb begin
    match = valid && (tag == look_tag);
  end

endmodule

module ptw_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int VPN_WIDTH      = 36
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [1:0]                     req_valid,
  input  logic [1:0][BUS_DATA_WIDTH-1:0] req_va,
  output logic [1:0]                     resp_valid,
  output logic [1:0][BUS_DATA_WIDTH-1:0] resp_pte,
  output logic                           walk_enable,
  output logic [BUS_DATA_WIDTH-1:0]      walk_va,
  input  logic                           walk_ready,
  input  logic [BUS_DATA_WIDTH-1:0]      walk_pte,
  output logic                           busy
);

  localparam int NUM_PORTS = 2;
  localparam int VPN_LSB   = 12;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic                                   gnt;
  logic                                   gnt_sel;
  logic                                   rr_last;
  logic                                   flush_sticky;
  logic                                   walk_done;
  logic                                   grant_take;
  logic [NUM_PORTS-1:0]                   match;
  logic [NUM_PORTS-1:0]                   hit;
  logic [NUM_PORTS-1:0]                   miss;
  logic [NUM_PORTS-1:0]                   in_flight;
  logic [NUM_PORTS-1:0]                   fill;
  logic [NUM_PORTS-1:0][BUS_DATA_WIDTH-1:0] cache_pte;

  assign walk_done  = (state == WAIT) && walk_ready;
  assign grant_take = (state == IDLE) && (|miss);
  // Tie goes to the port that was not served last; otherwise the lone miss.
  assign gnt_sel    = (miss == 2'b11) ? ~rr_last : miss[1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    // A port whose walk is outstanding must not hit on its own request;
    // a port already answered this cycle is masked until it drops or moves on.
    assign in_flight[p] = (state != IDLE) && (gnt == 1'(p));
    assign hit[p]       = req_valid[p] && match[p] && !in_flight[p] && !resp_valid[p];
    assign miss[p]      = req_valid[p] && !match[p] && !resp_valid[p];
    assign fill[p]      = walk_done && (gnt == 1'(p)) && !flush_sticky;

    ptw_entry #(
      .BUS_DATA_WIDTH(BUS_DATA_WIDTH),
      .VPN_WIDTH     (VPN_WIDTH)
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .fill    (fill[p]),
      .fill_tag(walk_va[VPN_LSB +: VPN_WIDTH]),
      .fill_pte(walk_pte),
      .look_tag(req_va[p][VPN_LSB +: VPN_WIDTH]),
      .match   (match[p]),
      .pte     (cache_pte[p])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and walker handshake outputs.
  always_comb begin
    state_nxt   = state;
    walk_enable = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:  if (|miss) state_nxt = ISSUE;
      ISSUE: begin
        walk_enable = 1'b1;
        state_nxt   = DRAIN;
      end
      // Walker may still be showing ready from the previous walk here.
      DRAIN: state_nxt = WAIT;
      WAIT:  if (walk_ready) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Responses, grant latch and walk address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= '0;
      resp_pte   <= '0;
      gnt        <= 1'b0;
      walk_va    <= '0;
      rr_last    <= 1'b1;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        resp_valid[p] <= hit[p] && !flush;
        if (hit[p] && !flush) resp_pte[p] <= cache_pte[p];
      end
      // A withdrawn requester still gets its cache filled, just no pulse.
      if (walk_done) begin
        resp_valid[gnt] <= req_valid[gnt];
        resp_pte[gnt]   <= walk_pte;
        rr_last         <= gnt;
      end
      if (grant_take) begin
        gnt     <= gnt_sel;
        walk_va <= req_va[gnt_sel];
      end
    end
  end

  // Remember a flush seen during a walk so its (possibly stale) result is not cached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         flush_sticky <= 1'b0;
    else if (state == RESP)             flush_sticky <= 1'b0;
    else if (flush && (state != IDLE))  flush_sticky <= 1'b1;
  end

endmodule
